// File: rtl/pmem_arb_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, grant sides and
// the round-robin pick between the instruction and data caches.
package pmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // On contention the side that did not win last time goes next.
    function automatic grant_e pick_grant(input logic i_req, input logic d_req,
                                          input grant_e last);
        if (i_req && d_req)
            return (last == GRANT_I) ? GRANT_D : GRANT_I;
        else if (d_req)
            return GRANT_D;
        else
            return GRANT_I;
    endfunction

endpackage

// File: rtl/pmem_arbiter.sv
// Two-port arbiter sharing one physical memory between the I-cache and D-cache.
// One transaction at a time; requests are latched at grant and replayed to pmem.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_e        state;
    grant_e            last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              read_q;
    logic              write_q;

    logic   i_req;
    logic   d_req;
    grant_e pick;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign pick  = pick_grant(i_req, d_req, last_grant);

    // NOTE: sequential state uses non-blocking assignments only; the latched
    // address/wdata are reset too because they drive pmem pins directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        last_grant <= pick;
                        if (pick == GRANT_D) begin
                            state   <= SERVE_D;
                            addr_q  <= d_address;
                            wdata_q <= d_wdata;
                            // A simultaneous read+write request is served as the writeback.
                            write_q <= d_write;
                            read_q  <= ~d_write;
                        end else begin
                            state   <= SERVE_I;
                            addr_q  <= i_address;
                            wdata_q <= '0;
                            write_q <= 1'b0;
                            read_q  <= 1'b1;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state   <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
